// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive path.
// SYNC is listed in wire order; its final bit is bit 0.
package usb_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RECV  = 3'd1,
      ST_SEND  = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERROR = 3'd4
   } state_e;

   localparam logic [7:0] SYNC_PATTERN = 8'b0000_0001;
   localparam int MAX_PKT_BITS = 88;
   localparam int STUFF_LIMIT  = 6;

   // Run of 1s that SYNC leaves pending for the stuffing counter.
   function automatic int sync_tail_ones();
      int n;
      n = 0;
      for (int i = 0; i < 8; i++)
         if (SYNC_PATTERN[i] && n == i)
            n++;
      return n;
   endfunction

endpackage

// File: rtl/bit_unstuffer_if.sv
// Receive bus between NRZI decoder, bit_unstuffer,
// bs_decoder and protocolFSM.
interface bit_unstuffer_if;

   logic rx_start;
   logic rx_valid;
   logic rx_bit;
   logic rx_eop;
   logic err_ack;
   logic start_decode;
   logic s_out;
   logic end_decode;
   logic rx_busy;
   logic rx_error;
   logic err_type;

   modport master (
      output rx_start, rx_valid, rx_bit, rx_eop, err_ack,
      input  start_decode, s_out, end_decode,
      input  rx_busy, rx_error, err_type
   );

   modport slave (
      input  rx_start, rx_valid, rx_bit, rx_eop, err_ack,
      output start_decode, s_out, end_decode,
      output rx_busy, rx_error, err_type
   );

endinterface

// File: rtl/rx_bit_buffer.sv
// Packet bit store: one flop per bit, single write port,
// single combinational read port.
module rx_bit_buffer #(
   parameter int MAX_BITS = 88,
   parameter int PW       = $clog2(MAX_BITS + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [PW-1:0] wr_ptr,
   input  logic          din,
   input  logic [PW-1:0] rd_ptr,
   output logic          dout
);

   localparam logic [PW-1:0] PTR_MAX = PW'(MAX_BITS);

   logic [MAX_BITS-1:0] mem_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         mem_q <= '0;
      else if (we && wr_ptr < PTR_MAX)
         mem_q[wr_ptr] <= din;
   end

   assign dout = (rd_ptr < PTR_MAX) ? mem_q[rd_ptr] : 1'b0;

endmodule

// File: rtl/bit_unstuffer.sv
// USB receive bit unstuffer: strips stuffed 0s, buffers the
// packet, then replays it as a gap-free burst after EOP.
module bit_unstuffer #(
   parameter int MAX_BITS    = usb_rx_pkg::MAX_PKT_BITS,
   parameter int STUFF_LIMIT = usb_rx_pkg::STUFF_LIMIT
) (
   input logic            clk,
   input logic            rst_n,
   bit_unstuffer_if.slave bus
);

   import usb_rx_pkg::*;

   localparam int PW = $clog2(MAX_BITS + 1);
   localparam int OW = $clog2(STUFF_LIMIT + 1);
   localparam logic [PW-1:0] PTR_MAX   = PW'(MAX_BITS);
   localparam logic [OW-1:0] ONES_MAX  = OW'(STUFF_LIMIT);
   localparam logic [OW-1:0] ONES_SYNC = OW'(sync_tail_ones());

   state_e        state_q, state_d;
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [OW-1:0] ones_q;
   logic          err_type_q;

   logic bit_in, at_limit, stuff_drop, stuff_err;
   logic overflow, push, last_bit, restart, buf_dout;

   always_comb begin
      restart    = bus.rx_start &&
                   (state_q == ST_IDLE || state_q == ST_RECV);
      bit_in     = state_q == ST_RECV && bus.rx_valid &&
                   !bus.rx_start && !bus.rx_eop;
      at_limit   = ones_q == ONES_MAX;
      stuff_drop = bit_in && at_limit && !bus.rx_bit;
      stuff_err  = bit_in && at_limit && bus.rx_bit;
      overflow   = bit_in && !at_limit && wr_ptr_q == PTR_MAX;
      push       = bit_in && !at_limit && wr_ptr_q != PTR_MAX;
      last_bit   = rd_ptr_q == wr_ptr_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:
            if (bus.rx_start) state_d = ST_RECV;
         ST_RECV:
            if (bus.rx_start)
               state_d = ST_RECV;
            else if (bus.rx_eop)
               state_d = (wr_ptr_q == '0) ? ST_IDLE : ST_SEND;
            else if (stuff_err || overflow)
               state_d = ST_ERROR;
         ST_SEND:
            if (last_bit) state_d = ST_DONE;
         ST_DONE:
            state_d = ST_IDLE;
         ST_ERROR:
            if (bus.err_ack) state_d = ST_IDLE;
         default:
            state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ones_q     <= '0;
         err_type_q <= 1'b0;
      end else begin
         if (restart) begin
            wr_ptr_q <= '0;
            ones_q   <= ONES_SYNC;
         end else if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            ones_q   <= bus.rx_bit ? ones_q + 1'b1 : '0;
         end else if (stuff_drop) begin
            ones_q   <= '0;
         end
         if (stuff_err) err_type_q <= 1'b0;
         if (overflow)  err_type_q <= 1'b1;
         // rd_ptr parks at 0 so the first SEND cycle replays bit 0
         if (state_q == ST_SEND)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         else
            rd_ptr_q <= '0;
      end
   end

   rx_bit_buffer #(
      .MAX_BITS (MAX_BITS),
      .PW       (PW)
   ) u_buf (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (push),
      .wr_ptr (wr_ptr_q),
      .din    (bus.rx_bit),
      .rd_ptr (rd_ptr_q),
      .dout   (buf_dout)
   );

   always_comb begin
      bus.start_decode = 1'b0;
      bus.s_out        = 1'b0;
      bus.end_decode   = 1'b0;
      bus.rx_busy      = 1'b0;
      bus.rx_error     = 1'b0;
      bus.err_type     = 1'b0;
      unique case (1'b1)
         state_q == ST_RECV:
            bus.rx_busy = 1'b1;
         state_q == ST_SEND: begin
            bus.rx_busy      = 1'b1;
            bus.s_out        = buf_dout;
            bus.start_decode = rd_ptr_q == '0;
         end
         state_q == ST_DONE:
            bus.end_decode = 1'b1;
         state_q == ST_ERROR: begin
            bus.rx_busy  = 1'b1;
            bus.rx_error = 1'b1;
            bus.err_type = err_type_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bit_unstuffer.sv
// Bench for bit_unstuffer: directed cases plus random packets
// built by a stuffing encoder and checked against the payload.
module tb_bit_unstuffer;

   import usb_rx_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   sd_seen;
   int   ed_seen;

   bit_unstuffer_if bus ();

   bit_unstuffer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.start_decode) sd_seen++;
      if (bus.end_decode)   ed_seen++;
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d @%0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Wire-side encoder: a 0 follows every run of six 1s,
   // counting SYNC's final 1.
   task automatic stuff(input bit p[$], output bit r[$],
                        output int sp[$]);
      int run;
      run = 1;
      r = {};
      sp = {};
      foreach (p[i]) begin
         r.push_back(p[i]);
         run = p[i] ? run + 1 : 0;
         if (run == STUFF_LIMIT) begin
            sp.push_back(r.size());
            r.push_back(1'b0);
            run = 0;
         end
      end
   endtask

   task automatic send_raw(input bit q[$], input bit gaps);
      bus.rx_start = 1'b1;
      step();
      bus.rx_start = 1'b0;
      foreach (q[i]) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            bus.rx_valid = 1'b0;
            step();
         end
         bus.rx_valid = 1'b1;
         bus.rx_bit   = q[i];
         step();
      end
      bus.rx_valid = 1'b0;
      bus.rx_bit   = 1'b0;
   endtask

   task automatic expect_burst(input bit exp[$]);
      int n;
      n = exp.size();
      bus.rx_eop = 1'b1;
      step();
      bus.rx_eop = 1'b0;
      if (n == 0) begin
         @(negedge clk);
         check("empty_busy", bus.rx_busy, 0);
         check("empty_start", bus.start_decode, 0);
         check("empty_end", bus.end_decode, 0);
      end else begin
         for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("start_decode", bus.start_decode, k == 0);
            check("s_out", bus.s_out, exp[k]);
            check("end_early", bus.end_decode, 0);
         end
         @(negedge clk);
         check("end_decode", bus.end_decode, 1);
         check("end_s_out", bus.s_out, 0);
         check("end_start", bus.start_decode, 0);
         @(negedge clk);
         check("idle_busy", bus.rx_busy, 0);
         check("idle_end", bus.end_decode, 0);
      end
   endtask

   task automatic expect_error(input logic et, input int hold);
      int sd0;
      int ed0;
      sd0 = sd_seen;
      ed0 = ed_seen;
      bus.rx_eop = 1'b1;
      step();
      bus.rx_eop = 1'b0;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check("rx_error", bus.rx_error, 1);
         check("err_type", bus.err_type, et);
         check("err_busy", bus.rx_busy, 1);
      end
      bus.err_ack = 1'b1;
      step();
      bus.err_ack = 1'b0;
      @(negedge clk);
      check("err_clear", bus.rx_error, 0);
      check("err_idle", bus.rx_busy, 0);
      check("err_no_start", sd_seen, sd0);
      check("err_no_end", ed_seen, ed0);
   endtask

   initial begin
      bit p[$];
      bit r[$];
      int sp[$];
      int mode;
      int len;
      int idx;

      checks = 0;
      errors = 0;
      sd_seen = 0;
      ed_seen = 0;
      rst_n = 1'b0;
      bus.rx_start = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_bit   = 1'b0;
      bus.rx_eop   = 1'b0;
      bus.err_ack  = 1'b0;
      #1;
      check("rst_start", bus.start_decode, 0);
      check("rst_s_out", bus.s_out, 0);
      check("rst_end", bus.end_decode, 0);
      check("rst_busy", bus.rx_busy, 0);
      check("rst_error", bus.rx_error, 0);
      check("rst_type", bus.err_type, 0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // ACK PID
      p = '{0, 1, 0, 0, 1, 0, 1, 1};
      send_raw(p, 0);
      expect_burst(p);

      // five 1s after SYNC force a stuffed 0
      r = '{1, 1, 1, 1, 1, 0, 1, 0};
      p = '{1, 1, 1, 1, 1, 1, 0};
      send_raw(r, 0);
      expect_burst(p);

      // six 1s after SYNC: stuff violation
      r = '{1, 1, 1, 1, 1, 1};
      send_raw(r, 0);
      expect_error(1'b0, 20);

      // exactly MAX bits, then one more
      p = {};
      for (int i = 0; i < MAX_PKT_BITS; i++) p.push_back(i[0]);
      send_raw(p, 0);
      expect_burst(p);
      send_raw(p, 0);
      @(negedge clk);
      check("ovf_88_ok", bus.rx_error, 0);
      bus.rx_valid = 1'b1;
      bus.rx_bit   = 1'b0;
      step();
      bus.rx_valid = 1'b0;
      @(negedge clk);
      check("ovf_89_err", bus.rx_error, 1);
      expect_error(1'b1, 2);

      // empty packet
      p = {};
      send_raw(p, 0);
      expect_burst(p);

      // reset during SEND bit 3
      p = '{1, 0, 1, 1, 0, 0, 1, 0};
      send_raw(p, 0);
      bus.rx_eop = 1'b1;
      step();
      bus.rx_eop = 1'b0;
      for (int k = 0; k < 4; k++) @(negedge clk);
      check("pre_rst_s_out", bus.s_out, 1);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_s_out", bus.s_out, 0);
      check("mid_rst_start", bus.start_decode, 0);
      check("mid_rst_end", bus.end_decode, 0);
      check("mid_rst_busy", bus.rx_busy, 0);
      step();
      rst_n = 1'b1;
      step();
      p = '{1, 1, 0, 1, 0, 0, 0, 1};
      send_raw(p, 1);
      expect_burst(p);

      for (int it = 0; it < 40; it++) begin
         mode = $urandom_range(0, 9);
         p = {};
         if (mode == 2) begin
            len = $urandom_range(0, 40);
            for (int i = 0; i < len; i++)
               p.push_back($urandom_range(0, 3) != 0);
            repeat (6) p.push_back(1'b1);
            len = $urandom_range(0, 30);
            for (int i = 0; i < len; i++)
               p.push_back($urandom_range(0, 3) != 0);
         end else begin
            if (mode == 0)
               len = 0;
            else if (mode == 1)
               len = $urandom_range(MAX_PKT_BITS + 1, 100);
            else
               len = $urandom_range(1, MAX_PKT_BITS);
            for (int i = 0; i < len; i++)
               p.push_back($urandom_range(0, 3) != 0);
         end
         stuff(p, r, sp);
         case (mode)
            0: begin
               send_raw(r, 0);
               expect_burst(p);
            end
            1: begin
               send_raw(r, 1);
               expect_error(1'b1, 3);
            end
            2: begin
               idx = sp[$urandom_range(0, sp.size() - 1)];
               r[idx] = 1'b1;
               send_raw(r, 1);
               expect_error(1'b0, 3);
            end
            default: begin
               if (sp.size() > 0 && sp[$] == r.size() - 1 &&
                   $urandom_range(0, 1) == 1)
                  void'(r.pop_back());
               send_raw(r, 1);
               expect_burst(p);
            end
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
